// File: rtl/knn_pkg.sv
// Shared definitions for the KNN inference path: default widths,
// controller state encoding and sizing helpers.
package knn_pkg;

  localparam int DIST_W_DEF = 32;
  localparam int TYPE_W_DEF = 3;
  localparam int NUM_TYPES  = 1 << TYPE_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VOTE,
    ST_ARGMAX,
    ST_DONE
  } state_t;

  // Number of classes for a given type width.
  function automatic int num_types(input int type_w);
    return 1 << type_w;
  endfunction

  // A histogram bin must hold counts 0..K inclusive.
  function automatic int hist_width(input int k);
    return $clog2(k + 1);
  endfunction

  // Index width for a K-entry list; at least one bit so K=1 still works.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/knn_sorted_buffer.sv
// K-entry sorted insertion list of {valid, dist, type}, nearest at index 0.
// All entries compare against the incoming distance in parallel so an
// insertion completes in a single cycle.
module knn_sorted_buffer
  import knn_pkg::*;
#(
  parameter int K      = 15,
  parameter int DIST_W = DIST_W_DEF,
  parameter int TYPE_W = TYPE_W_DEF,
  parameter int IDX_W  = idx_width(K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ins_en,
  input  logic [DIST_W-1:0] ins_dist,
  input  logic [TYPE_W-1:0] ins_type,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TYPE_W-1:0] rd_type
);

  logic [K-1:0]      valid_q;
  logic [DIST_W-1:0] dist_q [K];
  logic [TYPE_W-1:0] type_q [K];

  logic [K-1:0]      less;
  logic [K-1:0]      take_new;
  logic [K-1:0]      prev_valid;
  logic [DIST_W-1:0] prev_dist [K];
  logic [TYPE_W-1:0] prev_type [K];

  // Entry i is "behind" the new pair if it is empty or strictly farther;
  // equal distances keep the earlier arrival ahead.
  always_comb begin
    less     = '0;
    take_new = '0;
    for (int i = 0; i < K; i++) begin
      less[i] = !valid_q[i] || (ins_dist < dist_q[i]);
    end
    take_new[0] = less[0];
    for (int i = 1; i < K; i++) begin
      take_new[i] = less[i] && !less[i-1];
    end
  end

  // Neighbour view used by the shift: entry i receives entry i-1.
  for (genvar i = 0; i < K; i++) begin : g_prev
    if (i == 0) begin : g_head
      assign prev_valid[i] = 1'b0;
      assign prev_dist[i]  = '0;
      assign prev_type[i]  = '0;
    end else begin : g_body
      assign prev_valid[i] = valid_q[i-1];
      assign prev_dist[i]  = dist_q[i-1];
      assign prev_type[i]  = type_q[i-1];
    end
  end

  // Insert at the first "behind" slot, shift the rest down, drop the tail.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_q <= '0;
    end else if (ins_en) begin
      for (int i = 0; i < K; i++) begin
        if (take_new[i]) begin
          valid_q[i] <= 1'b1;
          dist_q[i]  <= ins_dist;
          type_q[i]  <= ins_type;
        end else if (less[i]) begin
          valid_q[i] <= prev_valid[i];
          dist_q[i]  <= prev_dist[i];
          type_q[i]  <= prev_type[i];
        end
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_type  = type_q[rd_idx];

endmodule

// File: rtl/knn_vote.sv
// Final stage of the KNN inference path: collects (distance, type) pairs
// into the sorted neighbour list, votes over the K nearest and reports the
// winning type with a one-cycle done pulse.
module knn_vote
  import knn_pkg::*;
#(
  parameter int K      = 15,
  parameter int L      = 6,
  parameter int DIST_W = DIST_W_DEF,
  parameter int TYPE_W = TYPE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dist_valid,
  output logic              dist_ready,
  input  logic [DIST_W-1:0] dist_in,
  input  logic [TYPE_W-1:0] type_in,
  input  logic              last_in,
  output logic              busy,
  output logic              inference_done,
  output logic [TYPE_W-1:0] inferred_type
);

  localparam int NTYPES = num_types(TYPE_W);
  localparam int HIST_W = hist_width(K);
  localparam int IDX_W  = idx_width(K);

  localparam logic [IDX_W-1:0]  V_LAST   = IDX_W'(K - 1);
  localparam logic [TYPE_W-1:0] A_LAST   = '1;
  localparam logic [L:0]        SAMP_MAX = {1'b1, {L{1'b0}}};

  state_t            state;
  logic [IDX_W-1:0]  v_idx;
  logic [TYPE_W-1:0] a_idx;
  logic [HIST_W-1:0] hist_q [NTYPES];
  logic [HIST_W-1:0] best_cnt;
  logic [TYPE_W-1:0] best_type;
  logic [L:0]        sample_cnt;

  logic              accept;
  logic              buf_clr;
  logic              rd_valid;
  logic [TYPE_W-1:0] rd_type;
  logic              better;

  assign accept  = dist_valid && dist_ready;
  assign buf_clr = (state == ST_IDLE) && start;
  assign better  = hist_q[a_idx] > best_cnt;

  knn_sorted_buffer #(
    .K      (K),
    .DIST_W (DIST_W),
    .TYPE_W (TYPE_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (buf_clr),
    .ins_en   (accept),
    .ins_dist (dist_in),
    .ins_type (type_in),
    .rd_idx   (v_idx),
    .rd_valid (rd_valid),
    .rd_type  (rd_type)
  );

  // Controller: collect, vote over the list, scan for the most frequent type.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      v_idx          <= '0;
      a_idx          <= '0;
      best_cnt       <= '0;
      best_type      <= '0;
      sample_cnt     <= '0;
      busy           <= 1'b0;
      dist_ready     <= 1'b0;
      inference_done <= 1'b0;
      inferred_type  <= '0;
      for (int t = 0; t < NTYPES; t++) hist_q[t] <= '0;
    end else begin
      inference_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int t = 0; t < NTYPES; t++) hist_q[t] <= '0;
            sample_cnt <= '0;
            busy       <= 1'b1;
            dist_ready <= 1'b1;
            state      <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            if (sample_cnt != SAMP_MAX) sample_cnt <= sample_cnt + 1'b1;
            if (last_in) begin
              dist_ready <= 1'b0;
              v_idx      <= '0;
              state      <= ST_VOTE;
            end
          end
        end
        ST_VOTE: begin
          if (rd_valid) hist_q[rd_type] <= hist_q[rd_type] + HIST_W'(1);
          if (v_idx == V_LAST) begin
            a_idx     <= '0;
            best_cnt  <= '0;
            best_type <= '0;
            state     <= ST_ARGMAX;
          end else begin
            v_idx <= v_idx + 1'b1;
          end
        end
        ST_ARGMAX: begin
          if (better) begin
            best_cnt  <= hist_q[a_idx];
            best_type <= a_idx;
          end
          if (a_idx == A_LAST) begin
            inferred_type  <= better ? a_idx : best_type;
            inference_done <= 1'b1;
            state          <= ST_DONE;
          end else begin
            a_idx <= a_idx + 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: a queue-based reference model picks the
// K nearest pairs by stable sort and votes; a monitor checks each done pulse.
module tb_knn_vote;

  localparam int K         = 15;
  localparam int DIST_W    = 32;
  localparam int TYPE_W    = 3;
  localparam int NUM_TYPES = 8;
  localparam int LAT       = K + NUM_TYPES + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic              dist_valid;
  logic              dist_ready;
  logic [DIST_W-1:0] dist_in;
  logic [TYPE_W-1:0] type_in;
  logic              last_in;
  logic              busy;
  logic              inference_done;
  logic [TYPE_W-1:0] inferred_type;

  typedef struct {
    int     typ;
    longint t_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   md[$];
  int   mt[$];
  int   errors = 0;
  int   checks = 0;

  knn_vote #(
    .K      (K),
    .L      (6),
    .DIST_W (DIST_W),
    .TYPE_W (TYPE_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .dist_valid     (dist_valid),
    .dist_ready     (dist_ready),
    .dist_in        (dist_in),
    .type_in        (type_in),
    .last_in        (last_in),
    .busy           (busy),
    .inference_done (inference_done),
    .inferred_type  (inferred_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: K nearest by distance, earlier arrival first on ties,
  // then plurality vote with ties going to the lowest type.
  function automatic int ref_vote();
    int cnt[NUM_TYPES];
    bit used[];
    int n;
    int best;
    used = new[md.size()];
    foreach (cnt[t]) cnt[t] = 0;
    n = (md.size() < K) ? md.size() : K;
    for (int s = 0; s < n; s++) begin
      int bi = -1;
      for (int i = 0; i < md.size(); i++)
        if (!used[i] && (bi < 0 || md[i] < md[bi])) bi = i;
      used[bi] = 1'b1;
      cnt[mt[bi]]++;
    end
    best = 0;
    for (int t = 1; t < NUM_TYPES; t++)
      if (cnt[t] > cnt[best]) best = t;
    return best;
  endfunction

  task automatic startInference();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    md.delete();
    mt.delete();
  endtask

  task automatic applyStimulus(input int d, input int t, input bit last, input bit expect_result);
    int guard = 0;
    while (!dist_ready && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!dist_ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    dist_valid = 1'b1;
    dist_in    = DIST_W'(d);
    type_in    = TYPE_W'(t);
    last_in    = last;
    @(posedge clk);
    md.push_back(d);
    mt.push_back(t);
    if (last && expect_result) sb.push_back('{ref_vote(), longint'($time)});
    #1;
    dist_valid = 1'b0;
    last_in    = 1'b0;
  endtask

  task automatic waitDone();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (sb.size() != 0) begin
      checkOutput("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && inference_done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("inferred_type", inferred_type, mon_e.typ);
        checkOutput("done_latency", (($time - mon_e.t_edge) + 5) / 10, LAT);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    dist_valid = 1'b0;
    dist_in    = '0;
    type_in    = '0;
    last_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", dist_ready, 0);
    checkOutput("rst_done", inference_done, 0);
    checkOutput("rst_type", inferred_type, 0);

    dist_valid = 1'b1;
    dist_in    = 5;
    type_in    = 7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("idle_ready", dist_ready, 0);
    end
    dist_valid = 1'b0;

    $display("[TB] 64 decreasing distances");
    startInference();
    for (int j = 0; j < 64; j++)
      applyStimulus(1000 - j, (j < 49) ? 0 : 5, j == 63, 1'b1);
    waitDone();

    $display("[TB] fewer than K samples");
    startInference();
    applyStimulus(10, 2, 1'b0, 1'b1);
    applyStimulus(20, 2, 1'b0, 1'b1);
    applyStimulus(30, 6, 1'b0, 1'b1);
    applyStimulus(40, 6, 1'b1, 1'b1);
    waitDone();

    $display("[TB] equal distances");
    startInference();
    for (int j = 0; j < 16; j++)
      applyStimulus(7, (j < 15) ? 3 : 1, j == 15, 1'b1);
    waitDone();

    $display("[TB] reset during vote");
    startInference();
    for (int j = 0; j < 15; j++)
      applyStimulus(j, 1, j == 14, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_type", inferred_type, 0);
    checkOutput("abort_ready", dist_ready, 0);
    repeat (30) @(posedge clk);
    #1;
    startInference();
    for (int j = 0; j < 15; j++)
      applyStimulus(100 + j, 4, j == 14, 1'b1);
    waitDone();

    $display("[TB] back-to-back and ignored start");
    startInference();
    for (int j = 0; j < 10; j++) begin
      if (j == 3) start = 1'b1;
      applyStimulus(int'($urandom_range(0, 50)), int'($urandom_range(0, 7)), j == 9, 1'b1);
      start = 1'b0;
    end
    waitDone();
    checkOutput("busy_after_done", busy, 0);
    startInference();
    checkOutput("b2b_busy", busy, 1);
    for (int j = 0; j < 20; j++)
      applyStimulus(int'($urandom_range(0, 50)), int'($urandom_range(0, 7)), j == 19, 1'b1);
    waitDone();

    $display("[TB] random inferences");
    for (int r = 0; r < 8; r++) begin
      int n = int'($urandom_range(1, 40));
      startInference();
      for (int j = 0; j < n; j++) begin
        int gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), j == n - 1, 1'b1);
      end
      waitDone();
    end

    repeat (5) @(posedge clk);
    #1 checkOutput("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
